adder_exhaustive_checker: RTL and testbench

- Synthesizable self-checking harness for small 2-operand adders, including exact and approximate variants with 4 inputs and 3 outputs.
- Generates every input vector in the team's canonical order, drives the DUT inputs, waits a settle window, samples the DUT outputs and compares them against the exact sum.
- Accumulates error metrics (mismatch count, max and summed absolute error) and streams per-vector results for logging.
- Acts as the response-reading end of the exhaustive adder stimulus flow, so on-chip/FPGA checks match simulation dumps.

---
 rtl/adder_exhaustive_checker.sv | 146 ++++++++++++++
 tb/tb_adder_exhaustive_checker.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_exhaustive_checker.sv
// Exhaustive stimulus/response checker for small 2-operand adders.
// Sweeps every input vector, compares the DUT sum to the exact sum and accumulates error metrics.
module adder_exhaustive_checker #(
  parameter int unsigned IN_W   = 4,
  parameter int unsigned OUT_W  = 3,
  parameter int unsigned SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic [IN_W-1:0]        pi,
  input  logic [OUT_W-1:0]       po,
  output logic                   busy,
  output logic                   done,
  output logic                   sample_valid,
  output logic [IN_W-1:0]        sample_idx,
  output logic [OUT_W-1:0]       sample_po,
  output logic                   sample_err,
  output logic [IN_W:0]          err_count,
  output logic [OUT_W:0]         max_err,
  output logic [IN_W+OUT_W:0]    sum_err
);

  localparam int unsigned HALF_W = IN_W / 2;
  localparam int unsigned SUM_W  = HALF_W + 1;
  localparam int unsigned CMP_W  = (OUT_W > SUM_W) ? OUT_W : SUM_W;
  localparam int unsigned MAX_W  = OUT_W + 1;
  localparam int unsigned EXT_W  = (CMP_W > MAX_W) ? CMP_W : MAX_W;
  localparam int unsigned CNT_W  = IN_W + 1;
  localparam int unsigned ACC_W  = IN_W + OUT_W + 1;
  localparam int unsigned SET_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t            state;
  logic [IN_W-1:0]   k;
  logic [SET_W-1:0]  settle_cnt;

  logic [SUM_W-1:0]  exact;
  logic [CMP_W-1:0]  po_ext;
  logic [CMP_W-1:0]  exact_ext;
  logic [CMP_W-1:0]  abs_err;
  logic [EXT_W-1:0]  abs_cmp;
  logic [EXT_W-1:0]  max_cmp;

  // Canonical order: each operand half is the bit-reverse of the matching half of k.
  function automatic logic [IN_W-1:0] vec_of(input logic [IN_W-1:0] idx);
    logic [IN_W-1:0] v;
    v = '0;
    for (int b = 0; b < int'(HALF_W); b++) begin
      v[int'(HALF_W) - 1 - b] = idx[b];
      v[int'(IN_W) - 1 - b]   = idx[int'(HALF_W) + b];
    end
    return v;
  endfunction

  // Exact reference and unsigned absolute error of the current response.
  always_comb begin
    exact     = SUM_W'(pi[IN_W-1:HALF_W]) + SUM_W'(pi[HALF_W-1:0]);
    po_ext    = CMP_W'(po);
    exact_ext = CMP_W'(exact);
    abs_err   = (po_ext >= exact_ext) ? (po_ext - exact_ext) : (exact_ext - po_ext);
    abs_cmp   = EXT_W'(abs_err);
    max_cmp   = EXT_W'(max_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      k            <= '0;
      settle_cnt   <= '0;
      pi           <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      sample_valid <= 1'b0;
      sample_idx   <= '0;
      sample_po    <= '0;
      sample_err   <= 1'b0;
      err_count    <= '0;
      max_err      <= '0;
      sum_err      <= '0;
    end else begin
      done         <= 1'b0;
      sample_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_SETTLE;
            k          <= '0;
            settle_cnt <= '0;
            busy       <= 1'b1;
            pi         <= vec_of('0);
            sample_idx <= '0;
            sample_po  <= '0;
            sample_err <= 1'b0;
            err_count  <= '0;
            max_err    <= '0;
            sum_err    <= '0;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == SET_W'(SETTLE - 1)) begin
            state      <= S_SAMPLE;
            settle_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        S_SAMPLE: begin
          sample_valid <= 1'b1;
          sample_idx   <= k;
          sample_po    <= po;
          sample_err   <= (abs_err != '0);
          err_count    <= err_count + CNT_W'(abs_err != '0);
          sum_err      <= sum_err + ACC_W'(abs_err);
          if (abs_cmp > max_cmp) begin
            max_err <= MAX_W'(abs_err);
          end
          // Last vector ends the run; done shares the cycle with its sample report.
          if (k == '1) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
            pi    <= '0;
          end else begin
            state <= S_SETTLE;
            k     <= k + 1'b1;
            pi    <= vec_of(k + 1'b1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_exhaustive_checker.sv
// Bench for adder_exhaustive_checker: behavioural adder models behind the checker, scoreboarded samples.
module tb_adder_exhaustive_checker;

  localparam int unsigned IN_W  = 4;
  localparam int unsigned OUT_W = 3;
  localparam int unsigned H     = IN_W / 2;
  localparam int unsigned N     = 1 << IN_W;

  // Expected sweep order for IN_W=4 (low operand varies fastest, halves bit-reversed).
  localparam logic [3:0] ORDER [16] = '{
    4'b0000, 4'b0010, 4'b0001, 4'b0011, 4'b1000, 4'b1010, 4'b1001, 4'b1011,
    4'b0100, 4'b0110, 4'b0101, 4'b0111, 4'b1100, 4'b1110, 4'b1101, 4'b1111
  };

  typedef struct {
    logic [IN_W-1:0]  idx;
    logic [IN_W-1:0]  pi;
    logic [OUT_W-1:0] po;
    logic             err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start3 = 1'b0;

  logic [IN_W-1:0]       pi, sample_idx, pi3, sample_idx3;
  logic [OUT_W-1:0]      po, sample_po, po3, sample_po3;
  logic                  busy, done, sample_valid, sample_err;
  logic                  busy3, done3, sample_valid3, sample_err3;
  logic [IN_W:0]         err_count, err_count3;
  logic [OUT_W:0]        max_err, max_err3;
  logic [IN_W+OUT_W:0]   sum_err, sum_err3;

  int unsigned mode = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int n_samp = 0;
  int done_cnt = 0;
  exp_t sb[$];
  exp_t e;
  logic [IN_W-1:0] prev_pi = '0;

  always #5 clk = ~clk;

  // Behavioural DUTs: 0 exact, 1 carry-out dropped, 2 stuck at zero.
  function automatic logic [OUT_W-1:0] model_po(input logic [IN_W-1:0] v, input int unsigned m);
    logic [H:0] s;
    s = (H+1)'(v[IN_W-1:H]) + (H+1)'(v[H-1:0]);
    case (m)
      1:       return OUT_W'(s) & 3'b011;
      2:       return '0;
      default: return OUT_W'(s);
    endcase
  endfunction

  always_comb po  = model_po(pi, mode);
  always_comb po3 = model_po(pi3, 0);

  adder_exhaustive_checker #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pi(pi), .po(po),
    .busy(busy), .done(done), .sample_valid(sample_valid),
    .sample_idx(sample_idx), .sample_po(sample_po), .sample_err(sample_err),
    .err_count(err_count), .max_err(max_err), .sum_err(sum_err)
  );

  adder_exhaustive_checker #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .pi(pi3), .po(po3),
    .busy(busy3), .done(done3), .sample_valid(sample_valid3),
    .sample_idx(sample_idx3), .sample_po(sample_po3), .sample_err(sample_err3),
    .err_count(err_count3), .max_err(max_err3), .sum_err(sum_err3)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Pop and compare every reported sample; pi is taken from the cycle before the report.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (sample_valid) begin
      n_samp++;
      if (sb.size() == 0) begin
        check("sb_underflow", 64'(sb.size()), 64'(1));
      end else begin
        e = sb.pop_front();
        check("sample_idx", 64'(sample_idx), 64'(e.idx));
        check("sample_pi",  64'(prev_pi),    64'(e.pi));
        check("sample_po",  64'(sample_po),  64'(e.po));
        check("sample_err", 64'(sample_err), 64'(e.err));
      end
    end
    prev_pi = pi;
  end

  task automatic load_sb(input int unsigned m);
    exp_t x;
    logic [H:0] ex;
    sb.delete();
    for (int k = 0; k < int'(N); k++) begin
      x.idx = IN_W'(k);
      x.pi  = ORDER[k];
      x.po  = model_po(ORDER[k], m);
      ex    = (H+1)'(ORDER[k][3:2]) + (H+1)'(ORDER[k][1:0]);
      x.err = (OUT_W'(ex) != x.po);
      sb.push_back(x);
    end
  endtask

  task automatic run(input int unsigned m, input int ec, input int em, input int es, input bit poke);
    int lat;
    int dc0;
    mode = m;
    load_sb(m);
    n_samp = 0;
    dc0 = done_cnt;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    lat = 1;
    check("busy_after_start", 64'(busy), 64'(1));
    while (!done && lat < 200) begin
      start = poke && (lat == 5 || lat == 20);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    if (!done) check("done_timeout", 64'(0), 64'(1));
    check("done_latency", 64'(lat), 64'(N * 2 + 1));
    check("busy_at_done", 64'(busy), 64'(0));
    check("pi_at_done", 64'(pi), 64'(0));
    check("last_valid_with_done", 64'(sample_valid), 64'(1));
    check("err_count", 64'(err_count), 64'(ec));
    check("max_err", 64'(max_err), 64'(em));
    check("sum_err", 64'(sum_err), 64'(es));
    // A start during the done cycle must be ignored.
    if (poke) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("done_one_cycle", 64'(done), 64'(0));
    check("n_samples", 64'(n_samp), 64'(N));
    check("sb_empty", 64'(sb.size()), 64'(0));
    check("done_pulses", 64'(done_cnt - dc0), 64'(1));
    repeat (3) @(negedge clk);
    check("idle_busy", 64'(busy), 64'(0));
    check("hold_err_count", 64'(err_count), 64'(ec));
    check("hold_sum_err", 64'(sum_err), 64'(es));
  endtask

  task automatic run3();
    int lat;
    int idx_exp;
    int hold [16];
    for (int v = 0; v < 16; v++) hold[v] = 0;
    idx_exp = 0;
    @(negedge clk) start3 = 1'b1;
    @(negedge clk) start3 = 1'b0;
    lat = 1;
    while (!done3 && lat < 400) begin
      if (busy3) hold[pi3]++;
      if (sample_valid3) begin
        check("s3_idx", 64'(sample_idx3), 64'(idx_exp));
        check("s3_err", 64'(sample_err3), 64'(0));
        idx_exp++;
      end
      @(negedge clk);
      lat++;
    end
    if (!done3) check("s3_done_timeout", 64'(0), 64'(1));
    check("s3_done_latency", 64'(lat), 64'(N * 4 + 1));
    check("s3_last_valid", 64'(sample_valid3), 64'(1));
    check("s3_last_idx", 64'(sample_idx3), 64'(N - 1));
    check("s3_n_samples", 64'(idx_exp + 1), 64'(N));
    check("s3_err_count", 64'(err_count3), 64'(0));
    check("s3_max_err", 64'(max_err3), 64'(0));
    check("s3_sum_err", 64'(sum_err3), 64'(0));
    for (int v = 0; v < 16; v++) check("s3_hold", 64'(hold[v]), 64'(4));
    @(negedge clk);
  endtask

  task automatic reset_abort();
    int dc0;
    mode = 0;
    load_sb(0);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (9) @(negedge clk);
    dc0 = done_cnt;
    check("abort_busy_before", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    check("abort_pi", 64'(pi), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_sample_idx", 64'(sample_idx), 64'(0));
    check("abort_sample_po", 64'(sample_po), 64'(0));
    check("abort_metrics", 64'({err_count, max_err, sum_err}), 64'(0));
    sb.delete();
    repeat (40) @(negedge clk);
    check("abort_no_done", 64'(done_cnt - dc0), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #12;
    check("rst_pi", 64'(pi), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_valid", 64'(sample_valid), 64'(0));
    check("rst_metrics", 64'({err_count, max_err, sum_err, sample_err}), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    run(0, 0, 0, 0, 1'b0);
    run(1, 6, 4, 24, 1'b0);
    run(2, 15, 6, 48, 1'b0);
    run(0, 0, 0, 0, 1'b1);
    run3();
    reset_abort();
    run(1, 6, 4, 24, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
